uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing,
// common to the receiver and transmitter.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Offset from the start-bit falling edge to the middle of the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input. The flops
// reset to RESET_VAL so that a quiet line does not look like an edge after reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1,
  parameter int   STAGES    = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start-bit falling edge, confirms it at
// mid-bit, then samples each data bit and the stop bit at bit centres.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);

  logic              rxd_s;
  logic              rxd_d_reg;
  logic              fall_edge;

  uart_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        data_sr_reg, data_sr_next;
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              frame_err_reg, frame_err_next;

  uart_sync #(
    .RESET_VAL (1'b1),
    .STAGES    (2)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rxd),
    .o_q     (rxd_s)
  );

  // A line held low never produces a new edge, so a break cannot retrigger.
  assign fall_edge = rxd_d_reg & ~rxd_s;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxd_d_reg     <= 1'b1;
      state_reg     <= ST_IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      data_sr_reg   <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rxd_d_reg     <= rxd_s;
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      data_sr_reg   <= data_sr_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    data_sr_next   = data_sr_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        baud_cnt_next = '0;
        if (fall_edge) begin
          bit_cnt_next = '0;
          state_next   = ST_START;
        end
      end

      ST_START: begin
        if (baud_cnt_reg == HALF_LAST) begin
          baud_cnt_next = '0;
          if (rxd_s) begin
            state_next = ST_IDLE;
          end else begin
            bit_cnt_next = '0;
            state_next   = ST_DATA;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          data_sr_next  = {rxd_s, data_sr_reg[7:1]};
          if (bit_cnt_reg == LAST_DATA) begin
            state_next = ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          state_next    = ST_IDLE;
          if (rxd_s) begin
            data_next  = data_sr_reg;
            valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = frame_err_reg;
  assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-accurate serial TX model pushes expected
// receive events; a monitor queues observed pulses that each test pops and compares.
`timescale 1ps/1ps
module tb_uart_rx;

  localparam int CPB         = 16;
  localparam int HALF_CLK_PS = 1000;
  localparam int BIT_PS      = CPB * 2 * HALF_CLK_PS;
  localparam int LAT_NOM     = 2 + CPB / 2 + 9 * CPB;

  // kind: 0 = o_valid, 1 = o_frame_err, 2 = both high together
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cycle;
  } ev_t;

  logic       clk     = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rxd   = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle_cnt    = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  ev_t  mon_ev;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #HALF_CLK_PS clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (o_valid || o_frame_err) begin
      mon_ev.kind  = (o_valid && o_frame_err) ? 2 : (o_valid ? 0 : 1);
      mon_ev.data  = o_data;
      mon_ev.cycle = cycle_cnt;
      obs_q.push_back(mon_ev);
      $display("[TB] rx event kind=%0d data=%h cycle=%0d", mon_ev.kind, mon_ev.data, mon_ev.cycle);
    end
  end

  task automatic align();
    @(posedge clk);
    #100;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_ps);
    i_rxd = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      i_rxd = data[i];
      #(bit_ps);
    end
    i_rxd = stop_bit;
    #(bit_ps);
  endtask

  task automatic push_exp(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind  = kind;
    e.data  = data;
    e.cycle = cycle_cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int n, input int max_cycles, output bit ok);
    int c;
    c = 0;
    while (obs_q.size() < n && c < max_cycles) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    #(10 * HALF_CLK_PS);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 00", o_data);
    end
    tests_run++;
    if ({o_valid, o_frame_err, o_busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid/ferr/busy=%b expected 000", {o_valid, o_frame_err, o_busy});
    end
    align();
    i_reset = 1'b1;
    repeat (50) @(negedge clk);
    tests_run++;
    if (o_busy !== 1'b0 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got busy=%b events=%0d expected busy=0 events=0", o_busy, obs_q.size());
    end
  endtask

  task automatic test_single();
    bit  ok;
    ev_t e, o;
    align();
    push_exp(0, 8'hA5);
    send_frame(8'hA5, 1'b1, BIT_PS);
    wait_obs(1, 40 * CPB, ok);
    repeat (2 * CPB) @(negedge clk);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_timeout: got %0d events expected 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.kind !== e.kind || o.data !== e.data) begin
        tests_failed++;
        $display("FAIL single_data: got kind=%0d data=%h expected kind=%0d data=%h", o.kind, o.data, e.kind, e.data);
      end
      tests_run++;
      if (o.cycle - e.cycle < LAT_NOM - 1 || o.cycle - e.cycle > LAT_NOM + 1) begin
        tests_failed++;
        $display("FAIL single_latency: got %0d cycles expected %0d +/-1", o.cycle - e.cycle, LAT_NOM);
      end
    end
    tests_run++;
    if (obs_q.size() != 0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_extra: got events=%0d busy=%b expected 0/0", obs_q.size(), o_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    ev_t e, o;
    align();
    push_exp(0, 8'h00);
    send_frame(8'h00, 1'b1, BIT_PS);
    push_exp(0, 8'hFF);
    send_frame(8'hFF, 1'b1, BIT_PS);
    wait_obs(2, 40 * CPB, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL b2b_timeout: got %0d events expected 2", obs_q.size());
      exp_q.delete();
      obs_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        tests_run++;
        if (o.kind !== e.kind || o.data !== e.data) begin
          tests_failed++;
          $display("FAIL b2b_data%0d: got kind=%0d data=%h expected kind=%0d data=%h", k, o.kind, o.data, e.kind, e.data);
        end
        tests_run++;
        if (o.cycle - e.cycle < LAT_NOM - 1 || o.cycle - e.cycle > LAT_NOM + 1) begin
          tests_failed++;
          $display("FAIL b2b_latency%0d: got %0d cycles expected %0d +/-1", k, o.cycle - e.cycle, LAT_NOM);
        end
      end
    end
    repeat (5 * CPB) @(negedge clk);
    tests_run++;
    if (o_data !== 8'hFF || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got data=%h events=%0d expected data=ff events=0", o_data, obs_q.size());
    end
  endtask

  task automatic test_frame_error();
    bit  ok;
    ev_t e, o;
    align();
    push_exp(1, 8'hFF);
    send_frame(8'h3C, 1'b0, BIT_PS);
    #(39 * BIT_PS);
    wait_obs(1, 4 * CPB, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL ferr_timeout: got %0d events expected 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.kind !== e.kind || o.data !== e.data) begin
        tests_failed++;
        $display("FAIL ferr_event: got kind=%0d data=%h expected kind=%0d data=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    tests_run++;
    if (obs_q.size() != 0 || o_busy !== 1'b0 || o_data !== 8'hFF) begin
      tests_failed++;
      $display("FAIL ferr_break: got events=%0d busy=%b data=%h expected 0/0/ff", obs_q.size(), o_busy, o_data);
    end
    i_rxd = 1'b1;
    #(2 * BIT_PS);
    align();
    push_exp(0, 8'h96);
    send_frame(8'h96, 1'b1, BIT_PS);
    wait_obs(1, 40 * CPB, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL ferr_recover_timeout: got %0d events expected 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.kind !== e.kind || o.data !== e.data) begin
        tests_failed++;
        $display("FAIL ferr_recover: got kind=%0d data=%h expected kind=%0d data=%h", o.kind, o.data, e.kind, e.data);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cycles;
    busy_cycles = 0;
    align();
    i_rxd = 1'b0;
    #(4 * 2 * HALF_CLK_PS);
    i_rxd = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (o_busy === 1'b1) busy_cycles++;
    end
    tests_run++;
    if (busy_cycles < 1 || busy_cycles > CPB / 2 + 4) begin
      tests_failed++;
      $display("FAIL glitch_busy: got %0d busy cycles expected 1..%0d", busy_cycles, CPB / 2 + 4);
    end
    tests_run++;
    if (o_busy !== 1'b0 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got busy=%b events=%0d expected 0/0", o_busy, obs_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    bit  ok;
    ev_t e, o;
    align();
    fork
      send_frame(8'h81, 1'b1, BIT_PS);
      begin
        #(5 * BIT_PS + BIT_PS / 2);
        i_reset = 1'b0;
      end
    join
    @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0 || o_busy !== 1'b0 || o_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_abort: got events=%0d busy=%b data=%h expected 0/0/00", obs_q.size(), o_busy, o_data);
    end
    align();
    i_reset = 1'b1;
    #(2 * BIT_PS);
    align();
    push_exp(0, 8'h81);
    send_frame(8'h81, 1'b1, BIT_PS);
    wait_obs(1, 40 * CPB, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midreset_timeout: got %0d events expected 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.kind !== e.kind || o.data !== e.data || obs_q.size() != 0) begin
        tests_failed++;
        $display("FAIL midreset_rx: got kind=%0d data=%h expected kind=%0d data=%h", o.kind, o.data, e.kind, e.data);
      end
    end
  endtask

  task automatic test_baud_sweep();
    bit  ok;
    int  bp;
    ev_t e, o;
    for (int pct = -3; pct <= 3; pct++) begin
      bp = BIT_PS * (100 + pct) / 100;
      push_exp(0, 8'h55);
      send_frame(8'h55, 1'b1, bp);
      #(2 * BIT_PS);
      wait_obs(1, 20 * CPB, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL sweep_timeout pct=%0d: got %0d events expected 1", pct, obs_q.size());
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        tests_run++;
        if (o.kind !== e.kind || o.data !== e.data || obs_q.size() != 0) begin
          tests_failed++;
          $display("FAIL sweep pct=%0d: got kind=%0d data=%h extra=%0d expected kind=%0d data=%h",
                   pct, o.kind, o.data, obs_q.size(), e.kind, e.data);
          obs_q.delete();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_baud_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #150000000;
    $display("FAIL watchdog: simulation did not complete, got %0d tests run", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
